// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encodings and frame constants shared by the boot loader files
package imem_loader_pkg;
  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  localparam int LANES = 4;
  localparam int LEN_W = 16;
  function automatic logic in_frame(input logic [2:0] s);
    return s == S_LEN1 || s == S_DATA || s == S_CSUM;
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, IMEM write port and core-reset/status bundle of the loader
interface imem_loader_if #(parameter int ADDR_WIDTH = 10);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  reload;
  logic                  imem_wr_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst_n;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (output in_data, in_valid, reload,
                  input in_ready, imem_wr_en, imem_addr, imem_wdata, core_rst_n, busy, done, err);
  modport slave (input in_data, in_valid, reload,
                 output in_ready, imem_wr_en, imem_addr, imem_wdata, core_rst_n, busy, done, err);
endinterface

// File: rtl/imem_loader_word_pack.sv
// imem_loader_word_pack: assembles four bytes LSB-first into a word and strobes it for one cycle
module imem_loader_word_pack import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        r_word_valid;
  assign o_last       = r_lane == 2'(LANES - 1);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;
  // bytes enter at the top so byte 0 lands in the LSB lane once four have shifted in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lane       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clr) begin
      r_lane       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_valid && o_last;
      if (i_valid) begin
        r_lane <= r_lane + 2'd1;
        r_word <= {i_byte, r_word[31:8]};
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader writing IMEM and holding the core in reset until a good frame lands
module imem_loader import imem_loader_pkg::*; #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int unsigned BASE_WORD      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam int MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [2:0]            r_state, w_next;
  logic                  r_ready, r_busy, r_done, r_err;
  logic [LEN_W-1:0]      r_len, r_word_idx, w_len;
  logic [7:0]            r_xor;
  logic [TW-1:0]         r_idle;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_xfer, w_reload, w_timeout, w_last_lane, w_last_word, w_word_end;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  assign w_xfer      = bus.in_valid & r_ready;
  assign w_len       = {bus.in_data, r_len[7:0]};
  assign w_reload    = bus.reload && (r_state == S_DONE || r_state == S_ERR);
  assign w_timeout   = in_frame(r_state) && !w_xfer && r_idle == TO_LAST;
  assign w_last_word = r_word_idx == r_len - 16'd1;
  assign w_word_end  = w_xfer && r_state == S_DATA && w_last_lane;
  imem_loader_word_pack u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_reload),
    .i_valid      (w_xfer && r_state == S_DATA),
    .i_byte       (bus.in_data),
    .o_last       (w_last_lane),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );
  // frame sequencing; an accepted byte beats a coincident timeout because w_timeout requires no xfer
  always_comb begin
    w_next = r_state;
    if (w_reload) w_next = S_LEN0;
    else if (w_timeout) w_next = S_ERR;
    else if (w_xfer)
      case (r_state)
        S_LEN0:  w_next = S_LEN1;
        S_LEN1:  w_next = w_len == '0 ? S_CSUM : int'(w_len) > MAX_WORDS ? S_ERR : S_DATA;
        S_DATA:  w_next = w_last_lane && w_last_word ? S_CSUM : S_DATA;
        S_CSUM:  w_next = bus.in_data == r_xor ? S_DONE : S_ERR;
        default: w_next = r_state;
      endcase
  end
  // registered state, status outputs, length/index/checksum bookkeeping and idle counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_LEN0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_xor      <= '0;
      r_idle     <= '0;
      r_addr     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next != S_DONE && w_next != S_ERR;
      r_busy  <= in_frame(w_next);
      r_done  <= w_next == S_DONE;
      r_err   <= w_next == S_ERR;
      r_idle  <= w_xfer || !in_frame(r_state) ? '0 : r_idle + TW'(1);
      if (w_reload) begin
        r_len      <= '0;
        r_word_idx <= '0;
        r_xor      <= '0;
      end else if (w_xfer) begin
        if (r_state != S_CSUM) r_xor <= r_xor ^ bus.in_data;
        if (r_state == S_LEN0) r_len[7:0] <= bus.in_data;
        if (r_state == S_LEN1) r_len[15:8] <= bus.in_data;
        if (w_word_end) begin
          r_word_idx <= r_word_idx + 16'd1;
          r_addr     <= ADDR_WIDTH'(32'(BASE_WORD) + 32'(r_word_idx));
        end
      end
    end
  assign bus.in_ready   = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.core_rst_n = r_done;
  assign bus.imem_wr_en = w_word_valid;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_word;
endmodule
